// File: rtl/regfile_pkg.sv
// Shared defaults and address-width helper for the register file scoreboard.
package regfile_pkg;

   localparam int unsigned DEF_DATA_W   = 32;
   localparam int unsigned DEF_NUM_REGS = 32;
   localparam int unsigned DEF_NUM_RD   = 2;
   localparam int unsigned DEF_ZERO_REG = 1;

   // Ceiling log2 with a floor of 1 so a two-entry file still gets a 1-bit address.
   function automatic int unsigned addr_w(input int unsigned n);
      int unsigned w;
      w = 1;
      while ((32'd1 << w) < n) begin
         w = w + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Read, writeback, reservation and flush signals between the pipeline and the register file.
interface regfile_scoreboard_if
   import regfile_pkg::*;
#(
   parameter int unsigned DATA_W   = DEF_DATA_W,
   parameter int unsigned NUM_REGS = DEF_NUM_REGS,
   parameter int unsigned NUM_RD   = DEF_NUM_RD
) ();

   localparam int unsigned ADDR_W = addr_w(NUM_REGS);

   logic [NUM_RD*ADDR_W-1:0] rd_addr;
   logic [NUM_RD*DATA_W-1:0] rd_data;
   logic [NUM_RD-1:0]        rd_busy;
   logic                     wr_en;
   logic [ADDR_W-1:0]        wr_addr;
   logic [DATA_W-1:0]        wr_data;
   logic                     rsv_en;
   logic [ADDR_W-1:0]        rsv_addr;
   logic                     flush;
   logic [NUM_REGS-1:0]      busy_vec;

   // Pipeline side: issues reads, writebacks and reservations.
   modport master (
      output rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, flush,
      input  rd_data, rd_busy, busy_vec
   );

   // Register file side.
   modport slave (
      input  rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, flush,
      output rd_data, rd_busy, busy_vec
   );

endinterface

// File: rtl/regfile_scoreboard_busy_tracker.sv
// Per-register reservation bits: reset > reserve > writeback clear > flush.
module rf_busy_tracker
   import regfile_pkg::*;
#(
   parameter int unsigned NUM_REGS = DEF_NUM_REGS,
   parameter int unsigned ZERO_REG = DEF_ZERO_REG,
   parameter int unsigned ADDR_W   = addr_w(NUM_REGS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                wr_en,
   input  logic [ADDR_W-1:0]   wr_addr,
   input  logic                rsv_en,
   input  logic [ADDR_W-1:0]   rsv_addr,
   input  logic                flush,
   output logic [NUM_REGS-1:0] busy
);

   localparam bit ZR = (ZERO_REG != 0);

   logic [NUM_REGS-1:0] busy_next;
   logic                rsv_ok;

   assign rsv_ok = rsv_en && !(ZR && (rsv_addr == '0));

   // Next busy vector: flush wipes, writeback clears, a new reservation always wins last.
   always_comb begin
      busy_next = flush ? '0 : busy;
      if (wr_en) begin
         busy_next[wr_addr] = 1'b0;
      end
      if (rsv_ok) begin
         busy_next[rsv_addr] = 1'b1;
      end
   end

   // Busy register with synchronous reset dominating every other request.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy <= '0;
      end else begin
         busy <= busy_next;
      end
   end

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-port register file with write-through bypass and a reservation scoreboard.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int unsigned DATA_W   = DEF_DATA_W,
   parameter int unsigned NUM_REGS = DEF_NUM_REGS,
   parameter int unsigned NUM_RD   = DEF_NUM_RD,
   parameter int unsigned ZERO_REG = DEF_ZERO_REG
) (
   input logic                 clk,
   input logic                 rst,
   regfile_scoreboard_if.slave bus
);

   localparam int unsigned ADDR_W = addr_w(NUM_REGS);
   localparam bit          ZR     = (ZERO_REG != 0);

   logic [DATA_W-1:0]   mem [NUM_REGS];
   logic [NUM_REGS-1:0] busy;
   logic                wr_ok;
   logic [ADDR_W-1:0]   ra;

   assign wr_ok = bus.wr_en && !(ZR && (bus.wr_addr == '0));

   rf_busy_tracker #(
      .NUM_REGS (NUM_REGS),
      .ZERO_REG (ZERO_REG),
      .ADDR_W   (ADDR_W)
   ) u_busy (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (bus.wr_en),
      .wr_addr  (bus.wr_addr),
      .rsv_en   (bus.rsv_en),
      .rsv_addr (bus.rsv_addr),
      .flush    (bus.flush),
      .busy     (busy)
   );

   assign bus.busy_vec = busy;

   // Data array: reset clears every entry, writes to the hardwired zero register are dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            mem[i] <= '0;
         end
      end else if (wr_ok) begin
         mem[bus.wr_addr] <= bus.wr_data;
      end
   end

   // Read ports: zero register first, then same-cycle writeback bypass (never busy), then array.
   always_comb begin
      bus.rd_data = '0;
      bus.rd_busy = '0;
      ra          = '0;
      for (int unsigned k = 0; k < NUM_RD; k++) begin
         ra = bus.rd_addr[k*ADDR_W +: ADDR_W];
         if (ZR && (ra == '0)) begin
            bus.rd_data[k*DATA_W +: DATA_W] = '0;
            bus.rd_busy[k]                  = 1'b0;
         end else if (bus.wr_en && (bus.wr_addr == ra)) begin
            bus.rd_data[k*DATA_W +: DATA_W] = bus.wr_data;
            bus.rd_busy[k]                  = 1'b0;
         end else begin
            bus.rd_data[k*DATA_W +: DATA_W] = mem[ra];
            bus.rd_busy[k]                  = busy[ra];
         end
      end
   end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed self-checking bench for regfile_scoreboard (32 x 32-bit, two read ports, zero register).
module tb_regfile_scoreboard;
   import regfile_pkg::*;

   typedef struct {
      bit          rst;
      bit          wr_en;
      logic [4:0]  wa;
      logic [31:0] wd;
      bit          rsv_en;
      logic [4:0]  rva;
      bit          flush;
      logic [4:0]  a0;
      logic [4:0]  a1;
      logic [31:0] ed0;
      logic [31:0] ed1;
      bit          eb0;
      bit          eb1;
      logic [31:0] ebv;
   } vec_t;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   vec_t tbl[$];

   regfile_scoreboard_if #(.DATA_W(32), .NUM_REGS(32), .NUM_RD(2)) bus ();

   regfile_scoreboard #(
      .DATA_W   (32),
      .NUM_REGS (32),
      .NUM_RD   (2),
      .ZERO_REG (1)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic vec_t mk(bit r, bit we, logic [4:0] wa, logic [31:0] wd,
                               bit re, logic [4:0] rva, bit fl,
                               logic [4:0] a0, logic [4:0] a1,
                               logic [31:0] ed0, logic [31:0] ed1,
                               bit eb0, bit eb1, logic [31:0] ebv);
      vec_t v;
      v.rst = r; v.wr_en = we; v.wa = wa; v.wd = wd;
      v.rsv_en = re; v.rva = rva; v.flush = fl;
      v.a0 = a0; v.a1 = a1;
      v.ed0 = ed0; v.ed1 = ed1; v.eb0 = eb0; v.eb1 = eb1; v.ebv = ebv;
      return v;
   endfunction

   task automatic drive(input vec_t v);
      rst          = v.rst;
      bus.wr_en    = v.wr_en;
      bus.wr_addr  = v.wa;
      bus.wr_data  = v.wd;
      bus.rsv_en   = v.rsv_en;
      bus.rsv_addr = v.rva;
      bus.flush    = v.flush;
      bus.rd_addr  = {v.a1, v.a0};
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_outputs(input string tag, input vec_t v);
      check({tag, ".d0"}, bus.rd_data[31:0], v.ed0);
      check({tag, ".d1"}, bus.rd_data[63:32], v.ed1);
      check({tag, ".b0"}, {31'd0, bus.rd_busy[0]}, {31'd0, v.eb0});
      check({tag, ".b1"}, {31'd0, bus.rd_busy[1]}, {31'd0, v.eb1});
      check({tag, ".bv"}, bus.busy_vec, v.ebv);
   endtask

   initial begin
      vec_t v;
      logic [31:0] pat;
      checks = 0;
      errors = 0;

      // Reset for two edges.
      drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      repeat (2) @(posedge clk);

      // Every register reads zero and idle on both ports after reset.
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         drive(mk(0, 0, 0, 0, 0, 0, 0, 5'(i), 5'(31 - i), 0, 0, 0, 0, 0));
         #1;
         check_outputs($sformatf("reset_rd[%0d]", i), mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      end

      //             rst we wa  wd            re rva fl a0  a1  ed0           ed1           eb0 eb1 ebv
      tbl.push_back(mk(0, 1, 5,  32'hDEADBEEF, 0, 0,  0, 5,  31, 32'hDEADBEEF, 0,            0, 0, 0));
      tbl.push_back(mk(0, 0, 0,  0,            0, 0,  0, 5,  0,  32'hDEADBEEF, 0,            0, 0, 0));
      tbl.push_back(mk(0, 1, 0,  32'h1234,     0, 0,  0, 0,  0,  0,            0,            0, 0, 0));
      tbl.push_back(mk(0, 0, 0,  0,            1, 0,  0, 0,  5,  0,            32'hDEADBEEF, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0,  0,            1, 7,  0, 0,  7,  0,            0,            0, 0, 0));
      tbl.push_back(mk(0, 0, 0,  0,            0, 0,  0, 0,  7,  0,            0,            0, 1, 32'h80));
      tbl.push_back(mk(0, 1, 7,  32'h55,       0, 0,  0, 7,  7,  32'h55,       32'h55,       0, 0, 32'h80));
      tbl.push_back(mk(0, 0, 0,  0,            0, 0,  0, 7,  5,  32'h55,       32'hDEADBEEF, 0, 0, 0));
      tbl.push_back(mk(0, 1, 9,  32'hA,        1, 9,  0, 9,  31, 32'hA,        0,            0, 0, 0));
      tbl.push_back(mk(0, 0, 0,  0,            0, 0,  0, 9,  9,  32'hA,        32'hA,        1, 1, 32'h200));
      tbl.push_back(mk(0, 0, 0,  0,            1, 3,  0, 3,  4,  0,            0,            0, 0, 32'h200));
      tbl.push_back(mk(0, 0, 0,  0,            1, 4,  0, 3,  4,  0,            0,            1, 0, 32'h208));
      tbl.push_back(mk(0, 0, 0,  0,            1, 6,  1, 4,  6,  0,            0,            1, 0, 32'h218));
      tbl.push_back(mk(0, 0, 0,  0,            0, 0,  0, 6,  9,  0,            32'hA,        1, 0, 32'h40));
      tbl.push_back(mk(1, 1, 6,  32'hF,        1, 8,  1, 6,  5,  32'hF,        32'hDEADBEEF, 0, 0, 32'h40));
      tbl.push_back(mk(0, 0, 0,  0,            0, 0,  0, 6,  5,  0,            0,            0, 0, 0));
      tbl.push_back(mk(0, 0, 0,  0,            0, 0,  0, 8,  9,  0,            0,            0, 0, 0));
      tbl.push_back(mk(0, 1, 31, 32'hCAFEF00D, 0, 0,  0, 31, 30, 32'hCAFEF00D, 0,            0, 0, 0));
      tbl.push_back(mk(0, 0, 0,  0,            1, 31, 0, 31, 31, 32'hCAFEF00D, 32'hCAFEF00D, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0,  0,            1, 31, 0, 31, 0,  32'hCAFEF00D, 0,            1, 0, 32'h80000000));
      tbl.push_back(mk(0, 0, 0,  0,            0, 0,  0, 31, 31, 32'hCAFEF00D, 32'hCAFEF00D, 1, 1, 32'h80000000));
      tbl.push_back(mk(0, 1, 31, 32'h1,        0, 0,  0, 31, 31, 32'h1,        32'h1,        0, 0, 32'h80000000));
      tbl.push_back(mk(0, 0, 0,  0,            0, 0,  0, 31, 31, 32'h1,        32'h1,        0, 0, 0));

      foreach (tbl[i]) begin
         @(negedge clk);
         drive(tbl[i]);
         #1;
         check_outputs($sformatf("vec[%0d]", i), tbl[i]);
      end

      // Fill every register, including 0 and 31, then read each back one cycle later.
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         pat = 32'h1000_0000 | (32'(i) * 32'h0101);
         drive(mk(0, 1, 5'(i), pat, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      end
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         pat = (i == 0) ? 32'h0 : (32'h1000_0000 | (32'(i) * 32'h0101));
         v = mk(0, 0, 0, 0, 0, 0, 0, 5'(i), 5'(i), pat, pat, 0, 0, 0);
         drive(v);
         #1;
         check_outputs($sformatf("fill_rd[%0d]", i), v);
      end

      // Reset again and confirm every entry is cleared.
      @(negedge clk);
      drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         v = mk(0, 0, 0, 0, 0, 0, 0, 5'(i), 5'(31 - i), 0, 0, 0, 0, 0);
         drive(v);
         #1;
         check_outputs($sformatf("rerst_rd[%0d]", i), v);
      end

      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 SHALL expose parameter DATA_W, default 32, register data width in bits.
REQ-002 SHALL expose parameter NUM_REGS, default 32, number of architectural registers (power of two, >= 2).
REQ-003 SHALL expose parameter NUM_RD, default 2, number of independent read ports (1..4).
REQ-004 SHALL expose parameter ZERO_REG, default 1; when 1, register 0 reads 0 and is never written or reserved.
REQ-005 SHALL derive localparam ADDR_W = clog2(NUM_REGS).
REQ-006 clk  in  1  sole clock; all state updates on rising edge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port k at bits [k*ADDR_W +: ADDR_W].
REQ-009 rd_data  out  NUM_RD*DATA_W  packed read data, same packing.
REQ-010 rd_busy  out  NUM_RD  per-port flag: addressed register has an outstanding reservation.
REQ-011 wr_en / wr_addr / wr_data  in  1 / ADDR_W / DATA_W  writeback port.
REQ-012 rsv_en / rsv_addr  in  1 / ADDR_W  destination reservation from issue stage.
REQ-013 flush  in  1  clear all reservations (pipeline squash).
REQ-014 busy_vec  out  NUM_REGS  current reservation bit per register.

Function
REQ-015 Reads SHALL be combinational from rd_addr; zero-cycle latency.
REQ-016 When wr_en=1 and wr_addr equals a port's rd_addr, that port SHALL return wr_data in the same cycle (write-through bypass).
REQ-017 With ZERO_REG=1, rd_addr=0 SHALL return 0 and rd_busy=0 regardless of writes or bypass.
REQ-018 Write SHALL update the array at the rising edge when wr_en=1 and rst=0; writes to register 0 dropped when ZERO_REG=1.
REQ-019 rsv_en=1 SHALL set busy[rsv_addr] at the next edge; reserve of register 0 ignored when ZERO_REG=1.
REQ-020 wr_en=1 SHALL clear busy[wr_addr] at the next edge.
REQ-021 Same-cycle rsv_en and wr_en to the same address: busy SHALL end at 1 (new producer wins); data still written.
REQ-022 rd_busy[k] SHALL equal busy[rd_addr_k] masked by same-cycle write to that address (bypassed value is not busy) unless rsv_en targets it as well, in which case rd_busy=0 this cycle and busy=1 next cycle.
REQ-023 flush=1 SHALL clear all busy bits at the next edge; a same-cycle rsv_en SHALL still set its bit (post-flush issue); register data unaffected by flush.
REQ-024 Reserving an already-busy register SHALL leave it busy (no counting); single write clears it.
REQ-025 Every one of NUM_REGS entries, including index NUM_REGS-1, SHALL be reachable for read, write and reset.

Reset
REQ-026 On a rising edge with rst=1 all NUM_REGS data entries SHALL become 0 and all busy bits 0.
REQ-027 rst SHALL dominate wr_en, rsv_en and flush in the same cycle.
REQ-028 After reset, rd_data SHALL read 0 on every port and rd_busy=0 unless bypassing a same-cycle write.

Structure
REQ-029 Default parameter values and ADDR_W derivation function SHALL live in shared package regfile_pkg.
REQ-030 Busy-bit tracking (set/clear/flush priority) SHALL be a sub-module named rf_busy_tracker; data array and bypass stay in the top.
REQ-031 Design SHALL be synthesizable with no latches and no multi-driven entries.

Verification
REQ-032 Reset then read all 32 registers on both ports -> all rd_data=0, busy_vec=0, including register 31.
REQ-033 Write r5=0xDEADBEEF while rd_addr0=5 -> rd_data0=0xDEADBEEF same cycle; next cycle unchanged with wr_en=0.
REQ-034 Write r0=0x1234 then read r0 -> 0; rsv_en on r0 -> busy_vec[0]=0.
REQ-035 rsv r7; next cycle rd_addr1=7 -> rd_busy1=1; write r7=0x55 -> rd_busy1=0, rd_data1=0x55 same cycle; busy_vec[7]=0 after edge.
REQ-036 rsv r9 and wr r9=0xA same cycle -> busy_vec[9]=1 next cycle, r9 reads 0xA.
REQ-037 rsv r3,r4; flush with rsv r6 same cycle -> busy_vec shows only bit 6; assert rst with wr_en r6=0xF -> r6 reads 0, busy_vec=0.
